// File: rtl/xor4_pkg.sv
// Shared types and constants for the registered 4-input odd-parity unit.
package xor4_pkg;

  typedef logic [3:0] nibble_t;  // bit 3 = A, bit 0 = D
  typedef logic [2:0] ones_t;

  localparam int unsigned LATENCY = 1;

  // Bit n set <=> nibble n has odd parity.
  localparam logic [15:0] ODD_MINTERMS = 16'b0110_1001_1001_0110;

endpackage

// File: rtl/xor4_core.sv
// Combinational parity leaf: sum-of-products odd-parity equation plus a 1's count.
module xor4_core
  import xor4_pkg::*;
(
  input  nibble_t nibble,
  output logic    parity,
  output ones_t   ones
);

  logic a, b, c, d;

  assign a = nibble[3];
  assign b = nibble[2];
  assign c = nibble[1];
  assign d = nibble[0];

  // One product term per odd-weight minterm: 1, 2, 4, 7, 8, 11, 13, 14.
  assign parity = (~a & ~b & ~c &  d)
                | (~a & ~b &  c & ~d)
                | (~a &  b & ~c & ~d)
                | (~a &  b &  c &  d)
                | ( a & ~b & ~c & ~d)
                | ( a & ~b &  c &  d)
                | ( a &  b & ~c &  d)
                | ( a &  b &  c & ~d);

  assign ones = {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d};

endmodule

// File: rtl/xor4_v_equation.sv
// Registered 4-input odd-parity unit with popcount and valid pulse.
// Optional running-XOR accumulator (i_clr/o_acc) is built when XOR4_ACCUM_EN is defined.
module xor4_v_equation
  import xor4_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_a,
  input  logic       i_b,
  input  logic       i_c,
  input  logic       i_d,
  input  logic       i_valid,
`ifdef XOR4_ACCUM_EN
  input  logic       i_clr,
  output logic       o_acc,
`endif
  output logic       o_f,
  output logic [2:0] o_ones,
  output logic       o_valid
);

  nibble_t nibble;
  logic    parity;
  ones_t   ones;

  logic    f_reg;
  ones_t   ones_reg;
  logic    valid_reg;

  assign nibble = {i_a, i_b, i_c, i_d};

  xor4_core u_core (
    .nibble (nibble),
    .parity (parity),
    .ones   (ones)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      f_reg     <= 1'b0;
      ones_reg  <= '0;
      valid_reg <= 1'b0;
    end else begin
      valid_reg <= i_valid;
      if (i_valid) begin
        f_reg    <= parity;
        ones_reg <= ones;
      end
    end
  end

  assign o_f     = f_reg;
  assign o_ones  = ones_reg;
  assign o_valid = valid_reg;

`ifdef XOR4_ACCUM_EN
  logic acc_reg;

  // Clear wins over a same-cycle accept; the sample still updates o_f/o_ones.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      acc_reg <= 1'b0;
    end else if (i_clr) begin
      acc_reg <= 1'b0;
    end else if (i_valid) begin
      acc_reg <= acc_reg ^ parity;
    end
  end

  assign o_acc = acc_reg;
`endif

endmodule

// File: tb/tb_xor4_v_equation.sv
// Directed self-checking bench for xor4_v_equation; accumulator steps run when XOR4_ACCUM_EN is defined.
module tb_xor4_v_equation;

  logic       clk;
  logic       rst_n;
  logic       a, b, c, d;
  logic       valid;
  logic       f;
  logic [2:0] ones;
  logic       vld_out;
`ifdef XOR4_ACCUM_EN
  logic       clr;
  logic       acc;
`endif

  int checks = 0;
  int errors = 0;

  // Hand-computed results for the sweep 0..15, 0, 1.
  logic       sweep_f    [18] = '{0,1,1,0, 1,0,0,1, 1,0,0,1, 0,1,1,0, 0,1};
  logic [2:0] sweep_ones [18] = '{0,1,1,2, 1,2,2,3, 1,2,2,3, 2,3,3,4, 0,1};

  xor4_v_equation dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_a     (a),
    .i_b     (b),
    .i_c     (c),
    .i_d     (d),
    .i_valid (valid),
`ifdef XOR4_ACCUM_EN
    .i_clr   (clr),
    .o_acc   (acc),
`endif
    .o_f     (f),
    .o_ones  (ones),
    .o_valid (vld_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic [3:0] n, input logic v);
    {a, b, c, d} = n;
    valid = v;
  endtask

  // Advance past the next rising edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1;
    put(4'($urandom_range(15)), 1'b1);
`ifdef XOR4_ACCUM_EN
    clr = 1'b0;
`endif
    #1 rst_n = 1'b0;

    // Reset held with random inputs.
    repeat (3) begin
      tick();
      put(4'($urandom_range(15)), 1'($urandom_range(1)));
    end
    check("rst_f", 8'(f), 8'h0);
    check("rst_ones", 8'(ones), 8'h0);
    check("rst_valid", 8'(vld_out), 8'h0);
`ifdef XOR4_ACCUM_EN
    check("rst_acc", 8'(acc), 8'h0);
`endif

    @(negedge clk);
    put(4'b0000, 1'b0);
    rst_n = 1'b1;

    // Exhaustive sweep, one accept per cycle.
    for (int i = 0; i < 18; i++) begin
      put(4'(i % 16), 1'b1);
      tick();
      check($sformatf("sweep_f[%0d]", i), 8'(f), 8'(sweep_f[i]));
      check($sformatf("sweep_ones[%0d]", i), 8'(ones), 8'(sweep_ones[i]));
      check($sformatf("sweep_valid[%0d]", i), 8'(vld_out), 8'h1);
      check($sformatf("sweep_inv[%0d]", i), 8'(f), 8'(ones[0]));
    end

    // Corner vectors called out individually.
    put(4'b1000, 1'b1);
    tick();
    check("n1000_f", 8'(f), 8'h1);
    check("n1000_ones", 8'(ones), 8'h1);
    put(4'b1111, 1'b1);
    tick();
    check("n1111_f", 8'(f), 8'h0);
    check("n1111_ones", 8'(ones), 8'h4);

    // Hold while i_valid is low.
    put(4'b0111, 1'b1);
    tick();
    check("hold_load_f", 8'(f), 8'h1);
    check("hold_load_ones", 8'(ones), 8'h3);
    put(4'b0000, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("hold_f[%0d]", i), 8'(f), 8'h1);
      check($sformatf("hold_ones[%0d]", i), 8'(ones), 8'h3);
      check($sformatf("hold_valid[%0d]", i), 8'(vld_out), 8'h0);
    end

`ifdef XOR4_ACCUM_EN
    // Clear without accept, then accumulate 0001, 0011, 0111 -> 1, 1, 0.
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("acc_clr_idle", 8'(acc), 8'h0);
    check("acc_clr_idle_valid", 8'(vld_out), 8'h0);
    put(4'b0001, 1'b1);
    tick();
    check("acc_0001", 8'(acc), 8'h1);
    put(4'b0011, 1'b1);
    tick();
    check("acc_0011", 8'(acc), 8'h1);
    put(4'b0111, 1'b1);
    tick();
    check("acc_0111", 8'(acc), 8'h0);
    put(4'b0001, 1'b1);
    tick();
    check("acc_pre_clr", 8'(acc), 8'h1);
    // Clear with a same-cycle accept.
    clr = 1'b1;
    put(4'b0001, 1'b1);
    tick();
    clr = 1'b0;
    check("acc_clr_accept", 8'(acc), 8'h0);
    check("acc_clr_accept_f", 8'(f), 8'h1);
    check("acc_clr_accept_valid", 8'(vld_out), 8'h1);
    put(4'b1011, 1'b1);
    tick();
    check("acc_after_clr", 8'(acc), 8'h1);
    put(4'b0000, 1'b0);
    tick();
    check("acc_idle_hold", 8'(acc), 8'h1);
`endif

    // Asynchronous clear: outputs drop without a clock edge.
    put(4'b1110, 1'b1);
    tick();
    check("async_pre_f", 8'(f), 8'h1);
    check("async_pre_ones", 8'(ones), 8'h3);
    put(4'b1110, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_f", 8'(f), 8'h0);
    check("async_ones", 8'(ones), 8'h0);
    check("async_valid", 8'(vld_out), 8'h0);
`ifdef XOR4_ACCUM_EN
    check("async_acc", 8'(acc), 8'h0);
`endif

    // In-flight sample discarded; no o_valid after release until a new accept.
    tick();
    @(negedge clk);
    put(4'b0000, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("post_rst_valid[%0d]", i), 8'(vld_out), 8'h0);
      check($sformatf("post_rst_f[%0d]", i), 8'(f), 8'h0);
    end
    put(4'b1101, 1'b1);
    tick();
    put(4'b0000, 1'b0);
    check("post_rst_accept_valid", 8'(vld_out), 8'h1);
    check("post_rst_accept_f", 8'(f), 8'h1);
    check("post_rst_accept_ones", 8'(ones), 8'h3);
    tick();
    check("post_rst_pulse_end", 8'(vld_out), 8'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
